// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder built from explicit one-bit full-adder cells.
// The combinational sum/carry is also registered for pipelined users.

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

module full_adder #(
    parameter int WIDTH = 1
) (
`ifdef GL_TEST
    inout  wire              vccd1,
    inout  wire              vssd1,
`endif
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             y,
    output logic             c,
    output logic [WIDTH-1:0] s,
    output logic             c_q,
    output logic [WIDTH-1:0] s_q
);

    // k[i] is the carry into bit i; k[WIDTH] is the carry-out.
    logic [WIDTH:0]   k;
    logic             c_d;
    logic [WIDTH-1:0] s_d;

    assign k[0] = y;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (k[i]),
            .s  (s[i]),
            .co (k[i+1])
        );
    end

    assign c = k[WIDTH];

    always_comb begin
        c_d = c;
        s_d = s;
    end

    // NOTE: async reset in the sensitivity list clears the outputs without a clock;
    // sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q <= 1'b0;
            s_q <= '0;
        end else begin
            c_q <= c_d;
            s_q <= s_d;
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: WIDTH=1 truth table, WIDTH=8 vectors,
// random and registered-path checks, and WIDTH=4 with clk/rst_n tied off.

module tb_full_adder;

    typedef struct {
        logic a;
        logic b;
        logic y;
        logic c;
        logic s;
    } vec1_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       y;
        logic       c;
        logic [7:0] s;
    } vec8_t;

    int tests = 0;
    int fails = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       a1, b1, y1, c1, s1, c1_q, s1_q;
    logic [7:0] a8, b8, s8, s8_q;
    logic       y8, c8, c8_q;
    logic [3:0] a4, b4, s4, s4_q;
    logic       y4, c4, c4_q;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .y(y1),
        .c(c1), .s(s1), .c_q(c1_q), .s_q(s1_q)
    );

    full_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .y(y8),
        .c(c8), .s(s8), .c_q(c8_q), .s_q(s8_q)
    );

    // clk and rst_n held inactive: only the combinational path is meaningful.
    full_adder #(.WIDTH(4)) dut4 (
        .clk(1'b0), .rst_n(1'b0), .a(a4), .b(b4), .y(y4),
        .c(c4), .s(s4), .c_q(c4_q), .s_q(s4_q)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    vec1_t t1[8];
    vec8_t t8[6];

    initial begin
        int exp_sum;

        t1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        t1[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        t1[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        t1[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        t1[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        t1[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        t1[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        t1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        t8[0] = '{8'hFF, 8'h00, 1'b1, 1'b1, 8'h00};
        t8[1] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF};
        t8[2] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
        t8[3] = '{8'h80, 8'h80, 1'b0, 1'b1, 8'h00};
        t8[4] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10};
        t8[5] = '{8'h55, 8'hAA, 1'b1, 1'b1, 8'h00};

        a1 = 0; b1 = 0; y1 = 0;
        a8 = 0; b8 = 0; y8 = 0;
        a4 = 4'h9; b4 = 4'h7; y4 = 0;

        #1;
        check("rst_c_q", {31'd0, c8_q}, 32'd0);
        check("rst_s_q", {24'd0, s8_q}, 32'd0);
        check("w4_tied_c", {31'd0, c4}, 32'd1);
        check("w4_tied_s", {28'd0, s4}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            a1 = t1[i].a; b1 = t1[i].b; y1 = t1[i].y;
            #1;
            check($sformatf("w1_c[%0d]", i), {31'd0, c1}, {31'd0, t1[i].c});
            check($sformatf("w1_s[%0d]", i), {31'd0, s1}, {31'd0, t1[i].s});
        end

        for (int i = 0; i < 6; i++) begin
            a8 = t8[i].a; b8 = t8[i].b; y8 = t8[i].y;
            #1;
            check($sformatf("w8_c[%0d]", i), {31'd0, c8}, {31'd0, t8[i].c});
            check($sformatf("w8_s[%0d]", i), {24'd0, s8}, {24'd0, t8[i].s});
        end

        // Still in reset after a clock edge.
        @(posedge clk); #1;
        check("rst_hold_c_q", {31'd0, c8_q}, 32'd0);
        check("rst_hold_s_q", {24'd0, s8_q}, 32'd0);

        // Release reset and capture 0x80 + 0x80.
        @(negedge clk);
        rst_n = 1'b1;
        a8 = 8'h80; b8 = 8'h80; y8 = 1'b0;
        @(posedge clk); #1;
        check("reg_c_q", {31'd0, c8_q}, 32'd1);
        check("reg_s_q", {24'd0, s8_q}, 32'd0);

        // Mid-cycle async reset clears registers but not the combinational sum.
        #2 rst_n = 1'b0;
        #1;
        check("async_c_q", {31'd0, c8_q}, 32'd0);
        check("async_s_q", {24'd0, s8_q}, 32'd0);
        check("async_c", {31'd0, c8}, 32'd1);
        check("async_s", {24'd0, s8}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        a8 = 8'h12; b8 = 8'h34; y8 = 1'b1;
        @(posedge clk); #1;
        check("release_s_q", {24'd0, s8_q}, 32'h47);
        // Inputs change between edges: registers hold.
        a8 = 8'hF0; b8 = 8'h20; y8 = 1'b0;
        #1;
        check("hold_c_q", {31'd0, c8_q}, 32'd0);
        check("hold_s_q", {24'd0, s8_q}, 32'h47);

        // Random vectors against plain integer arithmetic, combinational and registered.
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            y8 = 1'($urandom_range(0, 1));
            exp_sum = int'(a8) + int'(b8) + int'(y8);
            #1;
            check($sformatf("rnd_comb[%0d]", i), {23'd0, c8, s8}, 32'(exp_sum));
            @(posedge clk); #1;
            check($sformatf("rnd_reg[%0d]", i), {23'd0, c8_q, s8_q}, 32'(exp_sum));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
